// File: rtl/game_pkg.sv
// Shared game constants and channel-state encoding used by the spawner, collision and render blocks.
package game_pkg;

   localparam int POS_W     = 11;
   localparam int MAX_POS   = 600;
   localparam int UNDEF_POS = 1000;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_WAIT = 2'd1,
      ST_LIVE = 2'd2
   } chanState_e;

   // Rotate a 32-bit word left; amounts of 32 or more wrap around.
   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned sh);
      logic [63:0] doubled;
      doubled = {x, x} << (sh % 32);
      return doubled[63:32];
   endfunction

endpackage

// File: rtl/spawner_channel.sv
// One object channel: random spawn delay, clamped random position, then a fixed lifetime or a catch.
module spawner_channel
   import game_pkg::*;
#(
   parameter int MIN_DELAY = 1024,
   parameter int DELAY_W   = 26,
   parameter int LIFE_CYC  = 2**24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic [31:0]      rn_i,
   input  logic             catch_i,
   output logic [POS_W-1:0] position_o,
   output logic             valid_o,
   output logic             spawn_o,
   output logic             miss_o
);

   // One counter serves both the spawn delay and the object lifetime, so it must fit either.
   localparam int LIFE_W = $clog2(LIFE_CYC);
   localparam int CNT_W  = (DELAY_W > LIFE_W) ? DELAY_W : LIFE_W;
   localparam logic [DELAY_W:0]   MIN_EXT   = (DELAY_W+1)'(MIN_DELAY);
   localparam logic [CNT_W-1:0]   LIFE_LAST = CNT_W'(LIFE_CYC - 1);
   localparam logic [POS_W-1:0]   MAX_P     = POS_W'(MAX_POS);
   localparam logic [POS_W-1:0]   UNDEF_P   = POS_W'(UNDEF_POS);

   chanState_e          state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DELAY_W-1:0]  delayTarget_q, delayTarget_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                valid_q, valid_d;
   logic                spawn_q, spawn_d;
   logic                miss_q, miss_d;

   logic [DELAY_W:0]    delaySum;
   logic [DELAY_W-1:0]  delaySat;
   logic [POS_W-1:0]    rawPos;
   logic [POS_W-1:0]    clampPos;

   assign delaySum = {1'b0, rn_i[31 -: DELAY_W]} + MIN_EXT;
   assign delaySat = delaySum[DELAY_W] ? '1 : delaySum[DELAY_W-1:0];
   assign rawPos   = rn_i[POS_W-1:0];
   assign clampPos = (rawPos > MAX_P) ? MAX_P : rawPos;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_LOAD;
         count_q       <= '0;
         delayTarget_q <= '0;
         pos_q         <= UNDEF_P;
         valid_q       <= 1'b0;
         spawn_q       <= 1'b0;
         miss_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         delayTarget_q <= delayTarget_d;
         pos_q         <= pos_d;
         valid_q       <= valid_d;
         spawn_q       <= spawn_d;
         miss_q        <= miss_d;
      end
   end

   // A catch is honoured even while frozen; everything else only moves when enabled.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      delayTarget_d = delayTarget_q;
      pos_d         = pos_q;
      valid_d       = valid_q;
      spawn_d       = 1'b0;
      miss_d        = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (enable_i) begin
               delayTarget_d = delaySat;
               count_d       = '0;
               pos_d         = UNDEF_P;
               state_d       = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (enable_i) begin
               if (count_q == CNT_W'(delayTarget_q)) begin
                  pos_d   = clampPos;
                  valid_d = 1'b1;
                  spawn_d = 1'b1;
                  count_d = '0;
                  state_d = ST_LIVE;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         ST_LIVE: begin
            if (catch_i) begin
               pos_d   = UNDEF_P;
               valid_d = 1'b0;
               count_d = '0;
               state_d = ST_LOAD;
            end else if (enable_i) begin
               if (count_q == LIFE_LAST) begin
                  pos_d   = UNDEF_P;
                  valid_d = 1'b0;
                  miss_d  = 1'b1;
                  count_d = '0;
                  state_d = ST_LOAD;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
            pos_d   = UNDEF_P;
            valid_d = 1'b0;
         end
      endcase
   end

   assign position_o = pos_q;
   assign valid_o    = valid_q;
   assign spawn_o    = spawn_q;
   assign miss_o     = miss_q;

endmodule

// File: rtl/object_spawner.sv
// Multi-channel falling-object spawner: decorrelates the shared random word per channel and packs outputs.
module object_spawner
   import game_pkg::*;
#(
   parameter int N_OBJ     = 4,
   parameter int MIN_DELAY = 1024,
   parameter int DELAY_W   = 26,
   parameter int LIFE_CYC  = 2**24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [31:0]            random_number,
   input  logic [N_OBJ-1:0]       catch_hit,
   output logic [N_OBJ*POS_W-1:0] object_position,
   output logic [N_OBJ-1:0]       object_valid,
   output logic [N_OBJ-1:0]       spawn_pulse,
   output logic [N_OBJ-1:0]       miss_pulse
);

   // Each channel sees the random word rotated by 7*i so channels loading together diverge.
   for (genvar i = 0; i < N_OBJ; i++) begin : gChan
      logic [31:0] rnRot;
      assign rnRot = rotl32(random_number, 7 * i);

      spawner_channel #(
         .MIN_DELAY (MIN_DELAY),
         .DELAY_W   (DELAY_W),
         .LIFE_CYC  (LIFE_CYC)
      ) uChan (
         .clk        (clk),
         .rst        (rst),
         .enable_i   (enable),
         .rn_i       (rnRot),
         .catch_i    (catch_hit[i]),
         .position_o (object_position[i*POS_W +: POS_W]),
         .valid_o    (object_valid[i]),
         .spawn_o    (spawn_pulse[i]),
         .miss_o     (miss_pulse[i])
      );
   end

endmodule

// File: tb/tb_object_spawner.sv
// Directed bench for object_spawner with short delays and lifetime so every phase is reachable quickly.
module tb_object_spawner;

   localparam int N  = 4;
   localparam int PW = 11;

   logic            clk;
   logic            rst;
   logic            enable;
   logic [31:0]     randomNumber;
   logic [N-1:0]    catchHit;
   logic [N*PW-1:0] objPos;
   logic [N-1:0]    objValid;
   logic [N-1:0]    spawnPulse;
   logic [N-1:0]    missPulse;

   int compared   = 0;
   int mismatched = 0;
   int edgeIdx    = 0;

   object_spawner #(
      .N_OBJ     (N),
      .MIN_DELAY (4),
      .DELAY_W   (26),
      .LIFE_CYC  (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .random_number   (randomNumber),
      .catch_hit       (catchHit),
      .object_position (objPos),
      .object_valid    (objValid),
      .spawn_pulse     (spawnPulse),
      .miss_pulse      (missPulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PW-1:0] posOf(input int ch);
      return objPos[ch*PW +: PW];
   endfunction

   // Independent bit-by-bit rotation and clamp to predict each channel's spawn position.
   function automatic logic [PW-1:0] expPos(input logic [31:0] v, input int ch);
      logic [31:0] r;
      logic [PW-1:0] low;
      r = '0;
      for (int b = 0; b < 32; b++) r[(b + 7 * ch) % 32] = v[b];
      low = r[PW-1:0];
      return (low > 11'd600) ? 11'd600 : low;
   endfunction

   task automatic nextCycle();
      @(negedge clk);
      edgeIdx++;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; randomNumber = '0; catchHit = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         compared++;
         if (posOf(i) !== 11'd1000) begin
            mismatched++;
            $display("[TB] FAIL reset_pos[%0d]: got %0d expected 1000", i, posOf(i));
         end
      end
      compared++;
      if (objValid !== 4'h0) begin
         mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0000", objValid);
      end
      compared++;
      if ((spawnPulse | missPulse) !== 4'h0) begin
         mismatched++; $display("[TB] FAIL reset_pulses: got %b/%b expected 0", spawnPulse, missPulse);
      end
   endtask

   task automatic test_first_spawn();
      logic [N-1:0] expS;
      rst = 1'b0; enable = 1'b1; randomNumber = '0;
      edgeIdx = -1;
      repeat (6) begin
         nextCycle();
         expS = (edgeIdx == 5) ? 4'hF : 4'h0;
         compared++;
         if (spawnPulse !== expS) begin
            mismatched++; $display("[TB] FAIL first_spawn_pulse@%0d: got %b expected %b", edgeIdx, spawnPulse, expS);
         end
         compared++;
         if (objValid !== expS) begin
            mismatched++; $display("[TB] FAIL first_spawn_valid@%0d: got %b expected %b", edgeIdx, objValid, expS);
         end
      end
      for (int i = 0; i < N; i++) begin
         compared++;
         if (posOf(i) !== 11'd0) begin
            mismatched++; $display("[TB] FAIL first_spawn_pos[%0d]: got %0d expected 0", i, posOf(i));
         end
      end
   endtask

   task automatic test_expiry();
      logic [N-1:0] expV, expM, expS;
      repeat (16) begin
         nextCycle();
         expV = (edgeIdx <= 20) ? 4'hF : 4'h0;
         expM = (edgeIdx == 21) ? 4'hF : 4'h0;
         compared++;
         if (objValid !== expV) begin
            mismatched++; $display("[TB] FAIL expiry_valid@%0d: got %b expected %b", edgeIdx, objValid, expV);
         end
         compared++;
         if (missPulse !== expM) begin
            mismatched++; $display("[TB] FAIL expiry_miss@%0d: got %b expected %b", edgeIdx, missPulse, expM);
         end
      end
      compared++;
      if (posOf(1) !== 11'd1000) begin
         mismatched++; $display("[TB] FAIL expiry_pos: got %0d expected 1000", posOf(1));
      end
      repeat (6) begin
         nextCycle();
         expS = (edgeIdx == 27) ? 4'hF : 4'h0;
         compared++;
         if ((spawnPulse | missPulse) !== expS) begin
            mismatched++; $display("[TB] FAIL restart_spawn@%0d: got %b/%b expected %b", edgeIdx, spawnPulse, missPulse, expS);
         end
      end
      catchHit = 4'hF;
      nextCycle();
      catchHit = 4'h0;
      compared++;
      if ((objValid | missPulse) !== 4'h0) begin
         mismatched++; $display("[TB] FAIL catch_all: got %b/%b expected 0", objValid, missPulse);
      end
   endtask

   task automatic test_clamp();
      logic [31:0] vals [4];
      vals = '{32'd2047, 32'd599, 32'd600, 32'd601};
      foreach (vals[k]) begin
         randomNumber = '0;
         repeat (5) begin
            nextCycle();
            compared++;
            if (spawnPulse !== 4'h0) begin
               mismatched++; $display("[TB] FAIL clamp_early_spawn: got %b expected 0000", spawnPulse);
            end
         end
         randomNumber = vals[k];
         nextCycle();
         randomNumber = '0;
         compared++;
         if (spawnPulse !== 4'hF) begin
            mismatched++; $display("[TB] FAIL clamp_spawn: got %b expected 1111", spawnPulse);
         end
         for (int i = 0; i < N; i++) begin
            compared++;
            if (posOf(i) !== expPos(vals[k], i)) begin
               mismatched++;
               $display("[TB] FAIL clamp_pos[%0d] rn=%0d: got %0d expected %0d", i, vals[k], posOf(i), expPos(vals[k], i));
            end
         end
         catchHit = 4'hF;
         nextCycle();
         catchHit = 4'h0;
         compared++;
         if (objValid !== 4'h0 || posOf(0) !== 11'd1000) begin
            mismatched++; $display("[TB] FAIL clamp_clear: got %b/%0d expected 0000/1000", objValid, posOf(0));
         end
      end
   endtask

   task automatic test_catch_expiry();
      randomNumber = '0;
      for (int j = 0; j < 5; j++) begin
         catchHit = (j == 2) ? 4'hF : 4'h0;
         nextCycle();
         compared++;
         if ((spawnPulse | objValid) !== 4'h0) begin
            mismatched++; $display("[TB] FAIL wait_catch_ignored@%0d: got %b/%b expected 0", j, spawnPulse, objValid);
         end
      end
      catchHit = 4'h0;
      nextCycle();
      compared++;
      if (spawnPulse !== 4'hF) begin
         mismatched++; $display("[TB] FAIL ce_spawn: got %b expected 1111", spawnPulse);
      end
      repeat (15) begin
         nextCycle();
         compared++;
         if (objValid !== 4'hF || missPulse !== 4'h0) begin
            mismatched++; $display("[TB] FAIL ce_live: got %b/%b expected 1111/0000", objValid, missPulse);
         end
      end
      catchHit = 4'b0100;
      nextCycle();
      catchHit = 4'h0;
      compared++;
      if (missPulse !== 4'b1011) begin
         mismatched++; $display("[TB] FAIL ce_miss: got %b expected 1011", missPulse);
      end
      compared++;
      if (objValid !== 4'h0 || posOf(2) !== 11'd1000) begin
         mismatched++; $display("[TB] FAIL ce_clear: got %b/%0d expected 0000/1000", objValid, posOf(2));
      end
   endtask

   task automatic test_enable_pause();
      logic [N-1:0] expS;
      randomNumber = '0;
      for (int j = 0; j <= 105; j++) begin
         enable = !(j >= 3 && j < 103);
         nextCycle();
         expS = (j == 105) ? 4'hF : 4'h0;
         compared++;
         if (spawnPulse !== expS || missPulse !== 4'h0) begin
            mismatched++; $display("[TB] FAIL pause_spawn@%0d: got %b/%b expected %b/0000", j, spawnPulse, missPulse, expS);
         end
      end
      enable = 1'b0;
      repeat (3) nextCycle();
      compared++;
      if (objValid !== 4'hF) begin
         mismatched++; $display("[TB] FAIL frozen_live: got %b expected 1111", objValid);
      end
      catchHit = 4'b0010;
      nextCycle();
      catchHit = 4'h0;
      compared++;
      if (objValid !== 4'b1101 || posOf(1) !== 11'd1000 || posOf(0) !== 11'd0) begin
         mismatched++;
         $display("[TB] FAIL frozen_catch: got %b/%0d/%0d expected 1101/1000/0", objValid, posOf(1), posOf(0));
      end
      repeat (20) nextCycle();
      compared++;
      if (objValid !== 4'b1101 || missPulse !== 4'h0) begin
         mismatched++; $display("[TB] FAIL frozen_hold: got %b/%b expected 1101/0000", objValid, missPulse);
      end
   endtask

   task automatic test_reset_mid_live();
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         compared++;
         if (posOf(i) !== 11'd1000) begin
            mismatched++; $display("[TB] FAIL async_reset_pos[%0d]: got %0d expected 1000", i, posOf(i));
         end
      end
      compared++;
      if ((objValid | spawnPulse | missPulse) !== 4'h0) begin
         mismatched++; $display("[TB] FAIL async_reset_flags: got %b/%b/%b expected 0", objValid, spawnPulse, missPulse);
      end
      @(negedge clk);
      rst = 1'b0; enable = 1'b1;
      repeat (3) begin
         nextCycle();
         compared++;
         if ((objValid | missPulse) !== 4'h0) begin
            mismatched++; $display("[TB] FAIL post_reset: got %b/%b expected 0", objValid, missPulse);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_spawn();
      test_expiry();
      test_clamp();
      test_catch_expiry();
      test_enable_pause();
      test_reset_mid_live();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
